two_ch_rr_arb: RTL

- Two-channel round-robin packet arbiter that sits upstream of the team's 2:1 data mux.
- Chooses which source may transfer.
- Drives the mux select line (sel) and registers the selected beat into a one-entry output buffer with valid/ready handshake.
- Packet-locked: a grant is held from the first beat to the beat flagged last.

---
 rtl/two_ch_rr_arb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/two_ch_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : two_ch_rr_arb
// Purpose  : Two-channel packet-locked round-robin arbiter. Drives the 2:1
//            mux select and registers the granted beat into a one-entry
//            valid/ready output buffer. Keeps per-channel beat counters.
// Revision : 1.0 - initial release
// ============================================================================
module two_ch_rr_arb #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in0_valid,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_last,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_last,
  output logic          in1_ready,
  output logic          sel,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic [CW-1:0] beats0,
  output logic [CW-1:0] beats1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   ptr;        // channel favoured when both request in IDLE
  logic   next_ptr;
  logic   buf_free;   // output buffer can take a beat this cycle
  logic   acc0;
  logic   acc1;

  // Buffer is free when empty or being drained this cycle.
  assign buf_free = !out_valid || out_ready;

  // Ready is only offered to the granted channel.
  assign in0_ready = (state == GRANT0) && buf_free;
  assign in1_ready = (state == GRANT1) && buf_free;

  assign acc0 = in0_valid && in0_ready;
  assign acc1 = in1_valid && in1_ready;

  assign sel = (state == GRANT1);

  // Next-state and pointer logic; grant is held until the last beat.
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    case (state)
      IDLE: begin
        if (in0_valid && (!in1_valid || (ptr == 1'b0))) begin
          next_state = GRANT0;
        end else if (in1_valid) begin
          next_state = GRANT1;
        end
      end
      GRANT0: begin
        if (acc0 && in0_last) begin
          next_state = IDLE;
          next_ptr   = 1'b1;
        end
      end
      GRANT1: begin
        if (acc1 && in1_last) begin
          next_state = IDLE;
          next_ptr   = 1'b0;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State and round-robin pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 1'b0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
    end
  end

  // One-entry output buffer: a new accept overwrites a beat being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (acc0) begin
      out_valid <= 1'b1;
      out_data  <= in0_data;
      out_last  <= in0_last;
    end else if (acc1) begin
      out_valid <= 1'b1;
      out_data  <= in1_data;
      out_last  <= in1_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Per-channel accepted-beat counters, free-running with wrap-around.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats0 <= '0;
      beats1 <= '0;
    end else begin
      if (acc0) beats0 <= beats0 + 1'b1;
      if (acc1) beats1 <= beats1 + 1'b1;
    end
  end

endmodule
`default_nettype wire
